// File: rtl/sram1rw_param.sv
// Parametrised single-port 1RW SRAM behavioural macro.
// Configurable width and depth (depth need not be a power of two), per-group
// active-low write mask, optional output register with a read-valid strobe,
// and an optional clear sequencer that zeroes every word after reset release
// while holding BUSY high. Reads are read-before-write; out-of-range writes are
// dropped and out-of-range reads return zero with OV still asserted.
module sram1rw_param #(
  parameter int WIDTH          = 48,
  parameter int DEPTH          = 256,
  parameter int ADDR_W         = $clog2(DEPTH),
  parameter int MASK_GRAN      = 8,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                       CE,
  input  logic                       RSTB,
  input  logic                       CSB,
  input  logic                       WEB,
  input  logic                       OEB,
  input  logic [ADDR_W-1:0]          A,
  input  logic [WIDTH-1:0]           I,
  input  logic [WIDTH/MASK_GRAN-1:0] WMB,
  output logic [WIDTH-1:0]           O,
  output logic                       OV,
  output logic                       BUSY
);

  localparam int NGRP = WIDTH / MASK_GRAN;
  // One extra bit so DEPTH itself is representable for the range compare.
  localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  // Groups whose mask bit is low take the new data; the rest keep the old word.
  function automatic logic [WIDTH-1:0] merge_masked(
    input logic [WIDTH-1:0] old_word,
    input logic [WIDTH-1:0] new_word,
    input logic [NGRP-1:0]  wmb
  );
    logic [WIDTH-1:0] res;
    res = old_word;
    for (int g = 0; g < NGRP; g++) begin
      if (!wmb[g]) begin
        res[g*MASK_GRAN +: MASK_GRAN] = new_word[g*MASK_GRAN +: MASK_GRAN];
      end
    end
    return res;
  endfunction

  state_t             state_q;
  state_t             state_d;
  logic               busy;
  logic [ADDR_W-1:0]  clr_cnt_q;
  logic               re;
  logic               we;
  logic               a_ok;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic [WIDTH-1:0]   rd_data_p0;
  logic               vld_p0;

  assign re   = ~CSB & ~OEB & ~busy;
  assign we   = ~CSB & ~WEB & ~busy;
  assign a_ok = ({1'b0, A} < DEPTH_C);

  // Sequencer state register.
  always_ff @(posedge CE or negedge RSTB) begin
    if (!RSTB) begin
      state_q <= RST_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // Leave CLEAR once the last word has been zeroed.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_CLEAR && clr_cnt_q == LAST_ADDR) begin
      state_d = ST_READY;
    end
  end

  // BUSY is simply "clear in progress".
  always_comb begin
    busy = 1'b0;
    if (state_q == ST_CLEAR) begin
      busy = 1'b1;
    end
  end

  assign BUSY = busy;

  // Clear address counter; restarts from 0 on every reset.
  always_ff @(posedge CE or negedge RSTB) begin
    if (!RSTB) begin
      clr_cnt_q <= '0;
    end else if (busy) begin
      clr_cnt_q <= (clr_cnt_q == LAST_ADDR) ? '0 : clr_cnt_q + 1'b1;
    end
  end

  // Array update: clear writes take priority, user writes outside the array are dropped.
  // Word 0 is also rewritten with zero while reset is held in CLEAR; the clear that
  // follows release zeroes it anyway.
  always_ff @(posedge CE) begin
    if (busy) begin
      mem[clr_cnt_q] <= '0;
    end else if (we && a_ok) begin
      mem[A] <= merge_masked(mem[A], I, WMB);
    end
  end

  // ---- stage p0: array read, captured before this edge's write lands ----
  // Capture the addressed word on a read; hold the last value otherwise.
  always_ff @(posedge CE or negedge RSTB) begin
    if (!RSTB) begin
      rd_data_p0 <= '0;
      vld_p0     <= 1'b0;
    end else begin
      vld_p0 <= re;
      if (re) begin
        rd_data_p0 <= a_ok ? mem[A] : '0;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [WIDTH-1:0] rd_data_p1;
      logic             vld_p1;

      // ---- stage p1: optional output register, one extra cycle of latency ----
      // Forward each valid read one cycle later; hold O between reads.
      always_ff @(posedge CE or negedge RSTB) begin
        if (!RSTB) begin
          rd_data_p1 <= '0;
          vld_p1     <= 1'b0;
        end else begin
          vld_p1 <= vld_p0;
          if (vld_p0) begin
            rd_data_p1 <= rd_data_p0;
          end
        end
      end

      assign O  = rd_data_p1;
      assign OV = vld_p1;
    end else begin : g_no_out_reg
      assign O  = rd_data_p0;
      assign OV = vld_p0;
    end
  endgenerate

endmodule
